// File: rtl/dma_bound_checker_wr.sv
// AXI write-path bound checker: each write burst is matched against a table of
// [base, bound] windows; hits go downstream, misses are sunk and answered with SLVERR.
module dma_bound_checker_wr #(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 128,
  parameter int ID_W        = 5,
  parameter int CNT_W       = 16,
  parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s_axi_aw_valid,
  output logic                s_axi_aw_ready,
  input  logic [ID_W-1:0]     s_axi_aw_bits_id,
  input  logic [ADDR_W-1:0]   s_axi_aw_bits_addr,
  input  logic [7:0]          s_axi_aw_bits_len,
  input  logic [2:0]          s_axi_aw_bits_size,
  input  logic [1:0]          s_axi_aw_bits_burst,
  input  logic                s_axi_w_valid,
  output logic                s_axi_w_ready,
  input  logic [DATA_W-1:0]   s_axi_w_bits_data,
  input  logic [DATA_W/8-1:0] s_axi_w_bits_strb,
  input  logic                s_axi_w_bits_last,
  output logic                s_axi_b_valid,
  input  logic                s_axi_b_ready,
  output logic [ID_W-1:0]     s_axi_b_bits_id,
  output logic [1:0]          s_axi_b_bits_resp,
  output logic                m_axi_aw_valid,
  input  logic                m_axi_aw_ready,
  output logic [ID_W-1:0]     m_axi_aw_bits_id,
  output logic [ADDR_W-1:0]   m_axi_aw_bits_addr,
  output logic [7:0]          m_axi_aw_bits_len,
  output logic [2:0]          m_axi_aw_bits_size,
  output logic [1:0]          m_axi_aw_bits_burst,
  output logic                m_axi_w_valid,
  input  logic                m_axi_w_ready,
  output logic [DATA_W-1:0]   m_axi_w_bits_data,
  output logic [DATA_W/8-1:0] m_axi_w_bits_strb,
  output logic                m_axi_w_bits_last,
  input  logic                m_axi_b_valid,
  output logic                m_axi_b_ready,
  input  logic [ID_W-1:0]     m_axi_b_bits_id,
  input  logic [1:0]          m_axi_b_bits_resp,
  input  logic                cfg_enable,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W-1:0]   cfg_bound,
  input  logic                cfg_entry_valid,
  input  logic                err_clr,
  output logic                err_valid,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [ID_W-1:0]     err_id,
  output logic [CNT_W-1:0]    deny_count
);

  localparam int AW1 = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    FWD_AW = 3'd2,
    FWD_W  = 3'd3,
    FWD_B  = 3'd4,
    DENY_W = 3'd5,
    DENY_B = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [ADDR_W-1:0]   base_q  [NUM_ENTRIES];
  logic [ADDR_W-1:0]   bound_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q;
  logic                err_valid_q;
  logic [ADDR_W-1:0]   err_addr_q;
  logic [ID_W-1:0]     err_id_q;
  logic [CNT_W-1:0]    deny_q;

  logic [AW1-1:0]      nbytes_s, end_s;
  logic                hit_s, pass_s, miss_s, aw_hs_s;

  // Last byte of the burst in ADDR_W+1 bits so a wrap past the top is visible as a carry.
  always_comb begin
    nbytes_s = (AW1'(len_q) + AW1'(1'b1)) << size_q;
    end_s    = {1'b0, addr_q} + nbytes_s - AW1'(1'b1);
    hit_s    = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit_s = hit_s | (valid_q[i] && (base_q[i] <= addr_q) &&
                       (end_s[ADDR_W-1:0] <= bound_q[i]));
    end
    pass_s = !cfg_enable || (!end_s[ADDR_W] && hit_s);
    miss_s = (state_q == CHECK) && !pass_s;
  end

  // Next state and channel steering; W and B pass straight through in the FWD states.
  always_comb begin
    state_d           = state_q;
    s_axi_aw_ready    = 1'b0;
    s_axi_w_ready     = 1'b0;
    s_axi_b_valid     = 1'b0;
    s_axi_b_bits_id   = {ID_W{1'b0}};
    s_axi_b_bits_resp = 2'b00;
    m_axi_aw_valid    = 1'b0;
    m_axi_w_valid     = 1'b0;
    m_axi_b_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        s_axi_aw_ready = reset;
        if (s_axi_aw_valid && reset) state_d = CHECK;
        else                         state_d = IDLE;
      end
      CHECK: begin
        if (pass_s) state_d = FWD_AW;
        else        state_d = DENY_W;
      end
      FWD_AW: begin
        m_axi_aw_valid = 1'b1;
        if (m_axi_aw_ready) state_d = FWD_W;
        else                state_d = FWD_AW;
      end
      FWD_W: begin
        m_axi_w_valid = s_axi_w_valid;
        s_axi_w_ready = m_axi_w_ready;
        if (s_axi_w_valid && m_axi_w_ready && s_axi_w_bits_last) state_d = FWD_B;
        else                                                     state_d = FWD_W;
      end
      FWD_B: begin
        s_axi_b_valid     = m_axi_b_valid;
        s_axi_b_bits_id   = m_axi_b_bits_id;
        s_axi_b_bits_resp = m_axi_b_bits_resp;
        m_axi_b_ready     = s_axi_b_ready;
        if (m_axi_b_valid && s_axi_b_ready) state_d = IDLE;
        else                                state_d = FWD_B;
      end
      DENY_W: begin
        s_axi_w_ready = 1'b1;
        if (s_axi_w_valid && s_axi_w_bits_last) state_d = DENY_B;
        else                                    state_d = DENY_W;
      end
      DENY_B: begin
        s_axi_b_valid     = 1'b1;
        s_axi_b_bits_id   = id_q;
        s_axi_b_bits_resp = 2'b10;
        if (s_axi_b_ready) state_d = IDLE;
        else               state_d = DENY_B;
      end
      default: state_d = IDLE;
    endcase
  end

  assign aw_hs_s = (state_q == IDLE) && s_axi_aw_valid && reset;

  // FSM state and the captured AW fields of the burst in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= {ID_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (aw_hs_s) begin
        id_q    <= s_axi_aw_bits_id;
        addr_q  <= s_axi_aw_bits_addr;
        len_q   <= s_axi_aw_bits_len;
        size_q  <= s_axi_aw_bits_size;
        burst_q <= s_axi_aw_bits_burst;
      end else begin
        id_q    <= id_q;
      end
    end
  end

  // Bound table; writes land at the edge, so a CHECK cycle always sees the old contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= {NUM_ENTRIES{1'b0}};
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        base_q[i]  <= {ADDR_W{1'b0}};
        bound_q[i] <= {ADDR_W{1'b0}};
      end
    end else if (cfg_we) begin
      valid_q[cfg_idx] <= cfg_entry_valid;
      base_q[cfg_idx]  <= cfg_base;
      bound_q[cfg_idx] <= cfg_bound;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Violation log: a miss arriving with err_clr re-arms and captures in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= {ADDR_W{1'b0}};
      err_id_q    <= {ID_W{1'b0}};
      deny_q      <= {CNT_W{1'b0}};
    end else begin
      if (miss_s && (deny_q != {CNT_W{1'b1}})) deny_q <= deny_q + CNT_W'(1'b1);
      else                                     deny_q <= deny_q;
      if (miss_s && (!err_valid_q || err_clr)) begin
        err_valid_q <= 1'b1;
        err_addr_q  <= addr_q;
        err_id_q    <= id_q;
      end else if (err_clr) begin
        err_valid_q <= 1'b0;
      end else begin
        err_valid_q <= err_valid_q;
      end
    end
  end

  assign m_axi_aw_bits_id    = id_q;
  assign m_axi_aw_bits_addr  = addr_q;
  assign m_axi_aw_bits_len   = len_q;
  assign m_axi_aw_bits_size  = size_q;
  assign m_axi_aw_bits_burst = burst_q;
  assign m_axi_w_bits_data   = s_axi_w_bits_data;
  assign m_axi_w_bits_strb   = s_axi_w_bits_strb;
  assign m_axi_w_bits_last   = s_axi_w_bits_last;
  assign err_valid           = err_valid_q;
  assign err_addr            = err_addr_q;
  assign err_id              = err_id_q;
  assign deny_count          = deny_q;

endmodule

// File: tb/tb_dma_bound_checker_wr.sv
// Directed bench for dma_bound_checker_wr with a small deny counter (CNT_W=2) so
// saturation is reachable; expected AW addresses and B responses flow through queues.
module tb_dma_bound_checker_wr;
  localparam int NE = 8, AW = 64, DW = 128, IW = 5, CW = 2, XW = 3;

  logic clock = 1'b0, reset;
  logic s_axi_aw_valid, s_axi_aw_ready;
  logic [IW-1:0] s_axi_aw_bits_id;
  logic [AW-1:0] s_axi_aw_bits_addr;
  logic [7:0] s_axi_aw_bits_len;
  logic [2:0] s_axi_aw_bits_size;
  logic [1:0] s_axi_aw_bits_burst;
  logic s_axi_w_valid, s_axi_w_ready, s_axi_w_bits_last;
  logic [DW-1:0] s_axi_w_bits_data;
  logic [DW/8-1:0] s_axi_w_bits_strb;
  logic s_axi_b_valid, s_axi_b_ready;
  logic [IW-1:0] s_axi_b_bits_id;
  logic [1:0] s_axi_b_bits_resp;
  logic m_axi_aw_valid, m_axi_aw_ready;
  logic [IW-1:0] m_axi_aw_bits_id;
  logic [AW-1:0] m_axi_aw_bits_addr;
  logic [7:0] m_axi_aw_bits_len;
  logic [2:0] m_axi_aw_bits_size;
  logic [1:0] m_axi_aw_bits_burst;
  logic m_axi_w_valid, m_axi_w_ready, m_axi_w_bits_last;
  logic [DW-1:0] m_axi_w_bits_data;
  logic [DW/8-1:0] m_axi_w_bits_strb;
  logic m_axi_b_valid, m_axi_b_ready;
  logic [IW-1:0] m_axi_b_bits_id;
  logic [1:0] m_axi_b_bits_resp;
  logic cfg_enable, cfg_we, cfg_entry_valid, err_clr, err_valid;
  logic [XW-1:0] cfg_idx;
  logic [AW-1:0] cfg_base, cfg_bound, err_addr;
  logic [IW-1:0] err_id;
  logic [CW-1:0] deny_count;

  int compared = 0, mismatched = 0;
  logic [AW-1:0] aw_q[$];
  logic [IW+1:0] b_q[$];

  dma_bound_checker_wr #(.NUM_ENTRIES(NE), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .s_axi_aw_valid(s_axi_aw_valid), .s_axi_aw_ready(s_axi_aw_ready),
    .s_axi_aw_bits_id(s_axi_aw_bits_id), .s_axi_aw_bits_addr(s_axi_aw_bits_addr),
    .s_axi_aw_bits_len(s_axi_aw_bits_len), .s_axi_aw_bits_size(s_axi_aw_bits_size),
    .s_axi_aw_bits_burst(s_axi_aw_bits_burst),
    .s_axi_w_valid(s_axi_w_valid), .s_axi_w_ready(s_axi_w_ready),
    .s_axi_w_bits_data(s_axi_w_bits_data), .s_axi_w_bits_strb(s_axi_w_bits_strb),
    .s_axi_w_bits_last(s_axi_w_bits_last),
    .s_axi_b_valid(s_axi_b_valid), .s_axi_b_ready(s_axi_b_ready),
    .s_axi_b_bits_id(s_axi_b_bits_id), .s_axi_b_bits_resp(s_axi_b_bits_resp),
    .m_axi_aw_valid(m_axi_aw_valid), .m_axi_aw_ready(m_axi_aw_ready),
    .m_axi_aw_bits_id(m_axi_aw_bits_id), .m_axi_aw_bits_addr(m_axi_aw_bits_addr),
    .m_axi_aw_bits_len(m_axi_aw_bits_len), .m_axi_aw_bits_size(m_axi_aw_bits_size),
    .m_axi_aw_bits_burst(m_axi_aw_bits_burst),
    .m_axi_w_valid(m_axi_w_valid), .m_axi_w_ready(m_axi_w_ready),
    .m_axi_w_bits_data(m_axi_w_bits_data), .m_axi_w_bits_strb(m_axi_w_bits_strb),
    .m_axi_w_bits_last(m_axi_w_bits_last),
    .m_axi_b_valid(m_axi_b_valid), .m_axi_b_ready(m_axi_b_ready),
    .m_axi_b_bits_id(m_axi_b_bits_id), .m_axi_b_bits_resp(m_axi_b_bits_resp),
    .cfg_enable(cfg_enable), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base),
    .cfg_bound(cfg_bound), .cfg_entry_valid(cfg_entry_valid), .err_clr(err_clr),
    .err_valid(err_valid), .err_addr(err_addr), .err_id(err_id), .deny_count(deny_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [XW-1:0] idx, input logic [AW-1:0] b, input logic [AW-1:0] e,
                           input logic v);
    cfg_we = 1'b1; cfg_idx = idx; cfg_base = b; cfg_bound = e; cfg_entry_valid = v;
    @(posedge clock); #1 cfg_we = 1'b0;
  endtask

  // Called and returns one tick after a rising edge; stop_after>=0 abandons the burst mid-W.
  task automatic burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input bit fwd, input logic [1:0] dresp,
                       input bit clr_chk, input int stop_after);
    int n;
    logic [DW-1:0] wd;
    logic [IW+1:0] eb;
    if (fwd) begin aw_q.push_back(addr); b_q.push_back({id, dresp}); end
    else b_q.push_back({id, 2'b10});
    s_axi_aw_valid = 1'b1; s_axi_aw_bits_id = id; s_axi_aw_bits_addr = addr;
    s_axi_aw_bits_len = len; s_axi_aw_bits_size = size; s_axi_aw_bits_burst = 2'b01;
    n = 0;
    do begin @(negedge clock); n++; end while (!s_axi_aw_ready && n < 50);
    chk("s_aw_ready", s_axi_aw_ready, 1'b1);
    @(posedge clock); #1 s_axi_aw_valid = 1'b0; err_clr = clr_chk;
    @(negedge clock) chk("m_aw_valid_check_cycle", m_axi_aw_valid, 1'b0);
    @(posedge clock); #1 err_clr = 1'b0;
    @(negedge clock) chk("m_aw_valid_2cyc", m_axi_aw_valid, fwd);
    if (fwd) begin
      chk("m_aw_addr", m_axi_aw_bits_addr, aw_q.pop_front());
      chk("m_aw_id", m_axi_aw_bits_id, id);
      chk("m_aw_len", m_axi_aw_bits_len, len);
      m_axi_aw_ready = 1'b1;
    end
    @(posedge clock); #1 m_axi_aw_ready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == stop_after) return;
      wd = {$urandom, $urandom, $urandom, $urandom};
      s_axi_w_valid = 1'b1; s_axi_w_bits_data = wd; s_axi_w_bits_strb = 16'hFFFF;
      s_axi_w_bits_last = (b == int'(len)); m_axi_w_ready = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!s_axi_w_ready && n < 50);
      chk("s_w_ready", s_axi_w_ready, 1'b1);
      chk("m_w_valid", m_axi_w_valid, fwd);
      chk("m_aw_valid_in_w", m_axi_aw_valid, 1'b0);
      if (fwd) chk("m_w_data", m_axi_w_bits_data, wd);
      @(posedge clock); #1;
    end
    s_axi_w_valid = 1'b0; s_axi_w_bits_last = 1'b0;
    m_axi_b_valid = fwd; m_axi_b_bits_id = id; m_axi_b_bits_resp = dresp; s_axi_b_ready = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!s_axi_b_valid && n < 50);
    chk("s_b_valid", s_axi_b_valid, 1'b1);
    chk("m_b_ready", m_axi_b_ready, fwd);
    eb = b_q.pop_front();
    chk("s_b_id", s_axi_b_bits_id, eb[IW+1:2]);
    chk("s_b_resp", s_axi_b_bits_resp, eb[1:0]);
    @(posedge clock); #1 m_axi_b_valid = 1'b0; s_axi_b_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    {s_axi_aw_valid, s_axi_w_valid, s_axi_b_ready, m_axi_aw_ready, m_axi_w_ready, m_axi_b_valid} = 6'b0;
    s_axi_aw_bits_id = '0; s_axi_aw_bits_addr = '0; s_axi_aw_bits_len = 8'd0;
    s_axi_aw_bits_size = 3'd0; s_axi_aw_bits_burst = 2'd0; s_axi_w_bits_data = '0;
    s_axi_w_bits_strb = '0; s_axi_w_bits_last = 1'b0; m_axi_b_bits_id = '0; m_axi_b_bits_resp = 2'd0;
    cfg_enable = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_bound = '0;
    cfg_entry_valid = 1'b0; err_clr = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_s_aw_ready", s_axi_aw_ready, 1'b0);
    chk("rst_err_valid", err_valid, 1'b0);
    chk("rst_err_addr", err_addr, 64'd0);
    chk("rst_deny", deny_count, 2'd0);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock) chk("post_rst_aw_ready", s_axi_aw_ready, 1'b1);
    @(posedge clock); #1;

    // In-window burst is forwarded with OKAY relayed.
    cfg_write(3'd0, 64'h1000, 64'h1FFF, 1'b1);
    cfg_enable = 1'b1;
    burst(5'd3, 64'h1000, 8'd3, 3'd4, 1'b1, 2'b00, 1'b0, -1);
    chk("t1_deny", deny_count, 2'd0);
    chk("t1_err_valid", err_valid, 1'b0);

    // Burst straddling the bound is sunk and logged.
    burst(5'd5, 64'h1FC0, 8'd7, 3'd4, 1'b0, 2'b00, 1'b0, -1);
    chk("t2_err_valid", err_valid, 1'b1);
    chk("t2_err_addr", err_addr, 64'h1FC0);
    chk("t2_err_id", err_id, 5'd5);
    chk("t2_deny", deny_count, 2'd1);

    // End address wraps past the top of the address space.
    cfg_write(3'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    burst(5'd7, 64'hFFFF_FFFF_FFFF_FFF0, 8'd1, 3'd4, 1'b0, 2'b00, 1'b0, -1);
    chk("t3_deny", deny_count, 2'd2);
    chk("t3_err_addr_first", err_addr, 64'h1FC0);

    // Checking disabled with an empty table: everything passes.
    cfg_write(3'd0, 64'h0, 64'h0, 1'b0);
    cfg_enable = 1'b0;
    burst(5'd2, 64'h5000, 8'd0, 3'd3, 1'b1, 2'b01, 1'b0, -1);
    chk("t4_deny", deny_count, 2'd2);

    // Asynchronous reset in the middle of a forwarded W phase.
    cfg_enable = 1'b1;
    cfg_write(3'd0, 64'h1000, 64'h1FFF, 1'b1);
    burst(5'd4, 64'h1000, 8'd3, 3'd4, 1'b1, 2'b00, 1'b0, 2);
    #1 reset = 1'b0;
    #1;
    chk("arst_s_aw_ready", s_axi_aw_ready, 1'b0);
    chk("arst_s_w_ready", s_axi_w_ready, 1'b0);
    chk("arst_s_b_valid", s_axi_b_valid, 1'b0);
    chk("arst_m_aw_valid", m_axi_aw_valid, 1'b0);
    chk("arst_m_w_valid", m_axi_w_valid, 1'b0);
    chk("arst_m_b_ready", m_axi_b_ready, 1'b0);
    chk("arst_err_valid", err_valid, 1'b0);
    chk("arst_deny", deny_count, 2'd0);
    b_q.delete();
    s_axi_w_valid = 1'b0; s_axi_w_bits_last = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock) chk("arst_release_aw_ready", s_axi_aw_ready, 1'b1);
    @(posedge clock); #1;
    burst(5'd6, 64'h1000, 8'd0, 3'd4, 1'b0, 2'b00, 1'b0, -1);
    chk("arst_table_cleared_deny", deny_count, 2'd1);
    chk("arst_err_addr", err_addr, 64'h1000);

    // err_clr alone, then two misses, then clear-with-miss, then saturation.
    err_clr = 1'b1;
    @(posedge clock); #1 err_clr = 1'b0;
    chk("clr_err_valid", err_valid, 1'b0);
    chk("clr_deny", deny_count, 2'd1);
    burst(5'd8, 64'h3000, 8'd0, 3'd2, 1'b0, 2'b00, 1'b0, -1);
    chk("m1_err_addr", err_addr, 64'h3000);
    chk("m1_deny", deny_count, 2'd2);
    burst(5'd9, 64'h4000, 8'd0, 3'd2, 1'b0, 2'b00, 1'b0, -1);
    chk("m2_err_addr_holds", err_addr, 64'h3000);
    chk("m2_err_id_holds", err_id, 5'd8);
    chk("m2_deny", deny_count, 2'd3);
    burst(5'd10, 64'h6000, 8'd0, 3'd2, 1'b0, 2'b00, 1'b1, -1);
    chk("clrmiss_err_valid", err_valid, 1'b1);
    chk("clrmiss_err_addr", err_addr, 64'h6000);
    chk("clrmiss_err_id", err_id, 5'd10);
    burst(5'd11, 64'h7000, 8'd0, 3'd2, 1'b0, 2'b00, 1'b0, -1);
    chk("sat_deny", deny_count, 2'd3);
    chk("sat_err_addr", err_addr, 64'h6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
